// File: rtl/alu_result_sink.sv
`default_nettype none
//==============================================================================
// Module : alu_result_sink
// Desc   : ALU result receiver. MULT/DIV results load HI/LO, all others queue
//          in a writeback FIFO; status flags, sticky overflow, op counter.
// Rev    : 1.0  initial release
//==============================================================================
module alu_result_sink #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       fs,
    input  logic [31:0]      y_hi,
    input  logic [31:0]      y_lo,
    input  logic             c,
    input  logic             v,
    input  logic             n,
    input  logic             z,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [31:0]      hi_q,
    output logic [31:0]      lo_q,
    output logic [3:0]       flags_q,
    output logic             ovf_sticky,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam int               c_ptr_w    = $clog2(DEPTH);
    localparam logic [4:0]       c_fs_mult  = 5'h1E;
    localparam logic [4:0]       c_fs_div   = 5'h1F;
    localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w+1)'(DEPTH);
    localparam logic [c_ptr_w:0] c_cnt_one  = (c_ptr_w+1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [CNT_W-1:0] c_op_one   = CNT_W'(1);

    logic [31:0]        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [3:0]         r_flags;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_op_count;

    logic w_full;
    logic w_accept;
    logic w_muldiv;
    logic w_push;
    logic w_pop;

    // Backpressure depends only on occupancy, so a pop cannot open a slot
    // for an accept in the same cycle.
    assign w_full   = (r_count == c_full_cnt);
    assign in_ready = !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_muldiv = (fs == c_fs_mult) || (fs == c_fs_div);
    assign w_push   = w_accept && !w_muldiv;
    assign w_pop    = wb_valid && wb_ready;

    assign wb_valid   = (r_count != '0);
    assign wb_data    = r_mem[r_rd_ptr];
    assign hi_q       = r_hi;
    assign lo_q       = r_lo;
    assign flags_q    = r_flags;
    assign ovf_sticky = r_ovf;
    assign op_count   = r_op_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= y_lo;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_flags    <= '0;
            r_ovf      <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_flags    <= {c, v, n, z};
                r_op_count <= r_op_count + c_op_one;
                if (w_muldiv) begin
                    r_hi <= y_hi;
                    r_lo <= y_lo;
                end
            end
            // A new overflow takes priority over a clear in the same cycle.
            if (w_accept && v) begin
                r_ovf <= 1'b1;
            end else if (clr_sticky) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_sink.sv
`default_nettype none
//==============================================================================
// Module : tb_alu_result_sink
// Desc   : Directed vector table plus randomized traffic against a queue model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_alu_result_sink;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       fs;
    logic [31:0]      y_hi;
    logic [31:0]      y_lo;
    logic             c, v, n, z;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_data;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [3:0]       flags_q;
    logic             ovf_sticky;
    logic             clr_sticky;
    logic [CNT_W-1:0] op_count;

    alu_result_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fs         (fs),
        .y_hi       (y_hi),
        .y_lo       (y_lo),
        .c          (c),
        .v          (v),
        .n          (n),
        .z          (z),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .hi_q       (hi_q),
        .lo_q       (lo_q),
        .flags_q    (flags_q),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky),
        .op_count   (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic [4:0]  fs;
        logic [31:0] yh;
        logic [31:0] yl;
        logic [3:0]  cvnz;
        logic        rdy;
        logic        clr;
        logic        e_ir;
        logic        e_wbv;
        logic [31:0] e_wbd;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic [3:0]  e_flags;
        logic        e_stk;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl [10];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: an ordered queue of pending writebacks plus the
    // architectural state, advanced once per clock.
    logic [31:0] m_q [$];
    logic [31:0] m_hi, m_lo;
    logic [3:0]  m_flags;
    logic        m_stk;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hi = '0; m_lo = '0; m_flags = '0; m_stk = 1'b0; m_cnt = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; fs = '0; y_hi = '0; y_lo = '0;
        {c, v, n, z} = 4'h0; wb_ready = 1'b0; clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    // Drive one cycle of inputs, let one edge pass, advance the model.
    task automatic step(input logic iv, input logic [4:0] f, input logic [31:0] yh,
                        input logic [31:0] yl, input logic [3:0] cvnz,
                        input logic rdy, input logic clr);
        bit acc, pop, muldiv;
        in_valid = iv; fs = f; y_hi = yh; y_lo = yl;
        {c, v, n, z} = cvnz; wb_ready = rdy; clr_sticky = clr;
        acc    = iv && (m_q.size() < DEPTH);
        pop    = rdy && (m_q.size() > 0);
        muldiv = (f == 5'h1E) || (f == 5'h1F);
        @(posedge clk);
        #1;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            if (muldiv) begin
                m_hi = yh; m_lo = yl;
            end else begin
                m_q.push_back(yl);
            end
            m_flags = cvnz;
            m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        end
        if (acc && cvnz[2]) m_stk = 1'b1;
        else if (clr)       m_stk = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_q.size() < DEPTH));
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk({tag, ".wb_data"}, wb_data, m_q[0]);
        chk({tag, ".hi_q"}, hi_q, m_hi);
        chk({tag, ".lo_q"}, lo_q, m_lo);
        chk({tag, ".flags_q"}, 32'(flags_q), 32'(m_flags));
        chk({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'(m_stk));
        chk({tag, ".op_count"}, 32'(op_count), 32'(m_cnt));
    endtask

    initial begin
        logic [4:0]  rf;
        logic [3:0]  last_f;

        //             v    fs     y_hi          y_lo          cvnz  rdy   clr   ir    wbv   wbd           hi            lo            flags stk   cnt
        tbl[0] = '{1'b1, 5'h1E, 32'h00000001, 32'h80000000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00000001, 32'h80000000, 4'h0, 1'b0, 4'd1};
        tbl[1] = '{1'b1, 5'h04, 32'h12345678, 32'h0000000A, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000000A, 32'h00000001, 32'h80000000, 4'h1, 1'b0, 4'd2};
        tbl[2] = '{1'b1, 5'h04, 32'h0,        32'h0000000B, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000A, 32'h00000001, 32'h80000000, 4'h8, 1'b0, 4'd3};
        tbl[3] = '{1'b1, 5'h04, 32'h0,        32'h0000000C, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000A, 32'h00000001, 32'h80000000, 4'h8, 1'b0, 4'd3};
        tbl[4] = '{1'b1, 5'h04, 32'h0,        32'h0000000C, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000000B, 32'h00000001, 32'h80000000, 4'h8, 1'b0, 4'd3};
        tbl[5] = '{1'b1, 5'h04, 32'h0,        32'h0000000C, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000000C, 32'h00000001, 32'h80000000, 4'h4, 1'b1, 4'd4};
        tbl[6] = '{1'b1, 5'h04, 32'h0,        32'h0000000D, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000000C, 32'h00000001, 32'h80000000, 4'h4, 1'b1, 4'd5};
        tbl[7] = '{1'b0, 5'h04, 32'h0,        32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000000D, 32'h00000001, 32'h80000000, 4'h4, 1'b0, 4'd5};
        tbl[8] = '{1'b1, 5'h1F, 32'h0000DEAD, 32'h0000BEEF, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000DEAD, 32'h0000BEEF, 4'hE, 1'b1, 4'd6};
        tbl[9] = '{1'b0, 5'h00, 32'h0,        32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000DEAD, 32'h0000BEEF, 4'hE, 1'b1, 4'd6};

        do_reset();
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        chk("rst.hi_q", hi_q, 32'd0);
        chk("rst.op_count", 32'(op_count), 32'd0);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].fs, tbl[i].yh, tbl[i].yl, tbl[i].cvnz, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d.wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_wbv));
            if (tbl[i].e_wbv) chk($sformatf("tbl%0d.wb_data", i), wb_data, tbl[i].e_wbd);
            chk($sformatf("tbl%0d.hi_q", i), hi_q, tbl[i].e_hi);
            chk($sformatf("tbl%0d.lo_q", i), lo_q, tbl[i].e_lo);
            chk($sformatf("tbl%0d.flags_q", i), 32'(flags_q), 32'(tbl[i].e_flags));
            chk($sformatf("tbl%0d.ovf_sticky", i), 32'(ovf_sticky), 32'(tbl[i].e_stk));
            chk($sformatf("tbl%0d.op_count", i), 32'(op_count), 32'(tbl[i].e_cnt));
        end

        // Asynchronous reset mid-run with two entries queued.
        step(1'b1, 5'h1E, 32'hFFFF0000, 32'h0000FFFF, 4'h4, 1'b0, 1'b0);
        step(1'b1, 5'h02, 32'h0, 32'h11111111, 4'h0, 1'b0, 1'b0);
        step(1'b1, 5'h03, 32'h0, 32'h22222222, 4'h0, 1'b0, 1'b0);
        check_model("prerst");
        #3 reset_n = 1'b0;
        #1;
        chk("arst.wb_valid", 32'(wb_valid), 32'd0);
        chk("arst.hi_q", hi_q, 32'd0);
        chk("arst.lo_q", lo_q, 32'd0);
        chk("arst.ovf_sticky", 32'(ovf_sticky), 32'd0);
        in_valid = 1'b0; wb_ready = 1'b0; clr_sticky = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        step(1'b0, 5'h00, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("postrst.in_ready", 32'(in_ready), 32'd1);
        chk("postrst.wb_valid", 32'(wb_valid), 32'd0);
        chk("postrst.wb_data", wb_data, 32'd0);
        chk("postrst.op_count", 32'(op_count), 32'd0);
        chk("postrst.flags_q", 32'(flags_q), 32'd0);

        // Counter wrap: 17 accepts of mixed fs with the FIFO draining.
        last_f = 4'h0;
        for (int i = 0; i < 17; i++) begin
            rf = (i % 3 == 0) ? 5'h1E : ((i % 3 == 1) ? 5'h1F : 5'(i));
            last_f = 4'($urandom_range(0, 15));
            step(1'b1, rf, $urandom, $urandom, last_f, 1'b1, 1'b0);
            check_model($sformatf("wrap%0d", i));
        end
        chk("wrap.op_count", 32'(op_count), 32'd1);
        chk("wrap.flags_q", 32'(flags_q), 32'(last_f));

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rf = ($urandom_range(0, 3) == 0) ? (5'h1E | 5'($urandom_range(0, 1)))
                                             : 5'($urandom_range(0, 29));
            step(1'($urandom_range(0, 1)), rf, $urandom, $urandom,
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 7) == 0));
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
